// File: rtl/rom_rd_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port ROM. A granted burst
// issues len consecutive read strobes (wrapping at DATA_DEPTH) and returns each ROM
// word as a registered response tagged with the requester id and a last-word flag.
module rom_rd_arbiter #(
    parameter int unsigned ADDR_WD    = 8,
    parameter int unsigned DATA_WD    = 8,
    parameter int unsigned DATA_DEPTH = 48,
    parameter int unsigned LEN_WD     = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_vld,
    input  logic [ADDR_WD-1:0] req0_addr,
    input  logic [LEN_WD-1:0]  req0_len,
    output logic               req0_rdy,
    input  logic               req1_vld,
    input  logic [ADDR_WD-1:0] req1_addr,
    input  logic [LEN_WD-1:0]  req1_len,
    output logic               req1_rdy,
    output logic               rom_rd_vld,
    output logic [ADDR_WD-1:0] rom_rd_addr,
    input  logic [DATA_WD-1:0] rom_rd_data,
    input  logic               rom_rd_data_out_vld,
    output logic               rsp_vld,
    output logic [DATA_WD-1:0] rsp_data,
    output logic               rsp_id,
    output logic               rsp_last,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    // Highest legal ROM address; anything at or above it wraps to 0 on increment.
    localparam logic [ADDR_WD-1:0] LastAddr = ADDR_WD'(DATA_DEPTH - 1);

    state_e             state_q, state_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [LEN_WD-1:0]  cnt_q, cnt_d;
    logic               id_q, id_d;
    logic               prio_q, prio_d;   // requester favoured on the next contention
    logic               strb_q;           // a strobe was issued last cycle
    logic               strb_last_q;      // ...and it was the final strobe of the burst
    logic               rsp_vld_q, rsp_id_q, rsp_last_q;
    logic [DATA_WD-1:0] rsp_data_q;

    logic               grant;
    logic               grant_id;
    logic [LEN_WD-1:0]  len_sel;
    logic               rsp_take;

    // Round-robin pick: on contention the favoured requester wins, else whoever asks.
    always_comb begin
        grant_id = 1'b0;
        if (req0_vld && req1_vld) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1_vld;
        end
    end

    // Accept only in IDLE and never while reset is asserted, so outputs read 0 under reset.
    assign grant    = (state_q == StIdle) && !reset && (req0_vld || req1_vld);
    assign req0_rdy = grant && !grant_id;
    assign req1_rdy = grant && grant_id;
    assign len_sel  = grant_id ? req1_len : req0_len;

    // Burst sequencing: latch the winner, step address/count per strobe, wait for last word.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StIssue;
                    addr_d  = grant_id ? req1_addr : req0_addr;
                    cnt_d   = (len_sel == '0) ? LEN_WD'(1) : len_sel;
                    id_d    = grant_id;
                    prio_d  = ~grant_id;
                end
            end
            StIssue: begin
                addr_d = (addr_q >= LastAddr) ? '0 : addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == LEN_WD'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (rsp_vld_q && rsp_last_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

    assign rom_rd_vld  = (state_q == StIssue);
    assign rom_rd_addr = rom_rd_vld ? addr_q : '0;
    assign busy        = (state_q != StIdle);

    // ROM data is only trusted when it lines up with a strobe from the current burst.
    assign rsp_take = rom_rd_data_out_vld && strb_q;

    // Strobe tags delayed to meet the ROM data, then the registered response stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strb_q      <= 1'b0;
            strb_last_q <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            strb_q      <= rom_rd_vld;
            strb_last_q <= rom_rd_vld && (cnt_q == LEN_WD'(1));
            rsp_vld_q   <= rsp_take;
            rsp_data_q  <= rsp_take ? rom_rd_data : '0;
            rsp_id_q    <= rsp_take && id_q;
            rsp_last_q  <= rsp_take && strb_last_q;
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_last = rsp_last_q;

endmodule
